// File: rtl/score_table_if.sv
// Command, RAM and dump-stream signals of the score table controller.
// slave is the controller side; master is the side that drives commands and models the RAM.
interface score_table_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_id;
  logic [DATA_W-1:0] cmd_score;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_id;
  logic [DATA_W-1:0] out_score;
  logic              out_last;
  logic              out_parity;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_id, cmd_score, ram_rdata, out_ready,
    output cmd_ready, ram_addr, ram_wren, ram_wdata,
           out_valid, out_id, out_score, out_last, out_parity, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_id, cmd_score, ram_rdata, out_ready,
    input  cmd_ready, ram_addr, ram_wren, ram_wdata,
           out_valid, out_id, out_score, out_last, out_parity, err
  );
endinterface

// File: rtl/score_table_ctrl.sv
// Score table controller: write, saturating add and full-table dump over a
// single-port RAM with fixed read latency RD_LAT.
//   state    | meaning
//   IDLE     | ready for a command
//   WR       | one-cycle RAM write of the latched score
//   ADD_RD   | present the latched id to the RAM
//   ADD_WAIT | wait RD_LAT cycles, then capture the saturated sum
//   ADD_WR   | one-cycle RAM write of the sum
//   DMP_RD   | present the scan address to the RAM
//   DMP_WAIT | wait RD_LAT cycles, then register the read word as a beat
//   DMP_OUT  | hold the beat until out_ready
module score_table_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  score_table_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WR, ADD_RD, ADD_WAIT, ADD_WR, DMP_RD, DMP_WAIT, DMP_OUT
  } state_t;

  localparam logic [1:0]      OP_DUMP   = 2'b01;
  localparam logic [1:0]      OP_WRITE  = 2'b10;
  localparam logic [1:0]      OP_ADD    = 2'b11;
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C    = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [2:0]      WAIT_INIT = 3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] id_q, id_d;
  logic [DATA_W-1:0] score_q, score_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [2:0]        wait_q, wait_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_score_q, out_score_d;
  logic              out_last_q, out_last_d;
  logic              parity_q, parity_d;
  logic              err_q, err_d;

  logic [DATA_W:0]   sum_full;
  logic [DATA_W-1:0] sum_sat;
  logic              dump_st;

  // Carry-out of the widened sum selects the all-ones saturation value.
  assign sum_full = {1'b0, bus.ram_rdata} + {1'b0, score_q};
  assign sum_sat  = sum_full[DATA_W] ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];
  assign dump_st  = (state_q == DMP_RD) || (state_q == DMP_WAIT) || (state_q == DMP_OUT);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    score_d     = score_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    out_valid_d = out_valid_q;
    out_score_d = out_score_q;
    out_last_d  = out_last_q;
    parity_d    = parity_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          id_d    = bus.cmd_id;
          score_d = bus.cmd_score;
          if (bus.cmd_op == OP_DUMP) begin
            cnt_d   = '0;
            state_d = DMP_RD;
          end else if (bus.cmd_op == OP_WRITE || bus.cmd_op == OP_ADD) begin
            if ({1'b0, bus.cmd_id} >= DEPTH_C) err_d = 1'b1;
            else state_d = (bus.cmd_op == OP_WRITE) ? WR : ADD_RD;
          end
        end
      end
      WR:     state_d = IDLE;
      ADD_RD: begin
        wait_d  = WAIT_INIT;
        state_d = ADD_WAIT;
      end
      ADD_WAIT: begin
        if (wait_q == 3'd0) begin
          sum_d   = sum_sat;
          state_d = ADD_WR;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ADD_WR: state_d = IDLE;
      DMP_RD: begin
        wait_d  = WAIT_INIT;
        state_d = DMP_WAIT;
      end
      DMP_WAIT: begin
        if (wait_q == 3'd0) begin
          out_score_d = bus.ram_rdata;
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == LAST_C);
          state_d     = DMP_OUT;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      DMP_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          parity_d    = ~parity_q;
          if (out_last_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + (ADDR_W+1)'(1);
            state_d = DMP_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      id_q        <= '0;
      score_q     <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      out_valid_q <= 1'b0;
      out_score_q <= '0;
      out_last_q  <= 1'b0;
      parity_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      id_q        <= id_d;
      score_q     <= score_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      out_valid_q <= out_valid_d;
      out_score_q <= out_score_d;
      out_last_q  <= out_last_d;
      parity_q    <= parity_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.ram_wren   = (state_q == WR) || (state_q == ADD_WR);
  assign bus.ram_addr   = dump_st ? cnt_q[ADDR_W-1:0] : ((state_q == IDLE) ? '0 : id_q);
  assign bus.ram_wdata  = (state_q == WR) ? score_q : ((state_q == ADD_WR) ? sum_q : '0);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_id     = cnt_q[ADDR_W-1:0];
  assign bus.out_score  = out_score_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_parity = parity_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_score_table_ctrl.sv
// Scoreboard bench for score_table_ctrl: a RAM model with RD_LAT read pipeline,
// queues of expected writes, error pulses and dump beats, checked at the falling edge.
module tb_score_table_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 2;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  typedef struct {
    logic [ADDR_W-1:0] id;
    logic [DATA_W-1:0] score;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  wr_t   wr_q[$];
  beat_t beat_q[$];
  int    err_q[$];

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] mem [16];
  logic [DATA_W-1:0] pipe [RD_LAT];

  logic par_exp = 1'b0;
  bit   abort_mode = 1'b0;
  bit   stall_mode = 1'b0;
  int   stall_cnt = 0;
  int   n_stalled = 0;
  int   acc;

  score_table_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  score_table_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // RAM model: contents loaded on the first edge, read data RD_LAT cycles after the address
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++)
        mem[i] = (i == 7) ? 16'hFFF0 : ((i < 7) ? 16'(i + 1) : 16'h0000);
    end
    pipe[0] <= mem[bus.ram_addr[3:0]];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (bus.ram_wren) mem[bus.ram_addr[3:0]] = bus.ram_wdata;
  end
  assign bus.ram_rdata = pipe[RD_LAT-1];

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (abort_mode && bus.out_valid && bus.out_id == 16'd1) begin
        bus.out_ready = 1'b0;
      end else if (stall_mode && bus.out_valid && bus.out_id == 16'd2 && stall_cnt < 5) begin
        bus.out_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  wr_t   mon_w;
  beat_t mon_b;
  int    mon_e;

  always @(negedge clk) begin
    if (bus.ram_wren === 1'b1) begin
      if (wr_q.size() == 0) chk("spurious_wren", bus.ram_wren, 1'b0);
      else begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", bus.ram_addr, mon_w.addr);
        chk("wr_data", bus.ram_wdata, mon_w.data);
        chk("wr_cycle", cyc, mon_w.cyc);
      end
    end
    if (bus.err === 1'b1) begin
      if (err_q.size() == 0) chk("spurious_err", bus.err, 1'b0);
      else begin
        mon_e = err_q.pop_front();
        chk("err_cycle", cyc, mon_e);
      end
    end
    if (bus.out_valid === 1'b1) begin
      if (beat_q.size() == 0) chk("extra_beat", bus.out_valid, 1'b0);
      else begin
        mon_b = beat_q[0];
        chk("out_id", bus.out_id, mon_b.id);
        chk("out_score", bus.out_score, mon_b.score);
        chk("out_last", bus.out_last, mon_b.last);
        chk("out_parity", bus.out_parity, par_exp);
        if (bus.out_ready) begin
          void'(beat_q.pop_front());
          par_exp = ~par_exp;
        end else begin
          n_stalled++;
        end
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] id,
                          input logic [DATA_W-1:0] sc, input bit expect_it, output int acc_cyc);
    logic [DATA_W:0] s;
    int k;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_id    = id;
    bus.cmd_score = sc;
    for (int i = 0; i < 400 && !bus.cmd_ready; i++) @(negedge clk);
    acc_cyc = cyc;
    if (!bus.cmd_ready) begin
      chk("cmd_accept_timeout", bus.cmd_ready, 1'b1);
    end else if (expect_it) begin
      k = int'(id);
      if (op == 2'b01) begin
        for (int i = 0; i < DEPTH; i++)
          beat_q.push_back('{id: 16'(i), score: model[i], last: (i == DEPTH - 1)});
      end else if (op != 2'b00 && k >= DEPTH) begin
        err_q.push_back(acc_cyc + 1);
      end else if (op == 2'b10) begin
        model[k] = sc;
        wr_q.push_back('{addr: id, data: sc, cyc: acc_cyc + 1});
      end else if (op == 2'b11) begin
        s = {1'b0, model[k]} + {1'b0, sc};
        model[k] = s[DATA_W] ? 16'hFFFF : s[DATA_W-1:0];
        wr_q.push_back('{addr: id, data: model[k], cyc: acc_cyc + 2 + RD_LAT});
      end
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_id    = ~id;
    bus.cmd_score = ~sc;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((wr_q.size() != 0 || beat_q.size() != 0 || err_q.size() != 0 || !bus.cmd_ready)
           && i < 500) begin
      @(negedge clk);
      i++;
    end
    if (i >= 500) chk("drain_timeout", i, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    @(posedge clk);
    #1;
    beat_q.delete();
    par_exp = 1'b0;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_wren", bus.ram_wren, 1'b0);
    chk("rst_ready", bus.cmd_ready, 1'b0);
    repeat (n) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    chk("watchdog", cyc, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_id    = '0;
    bus.cmd_score = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = (i == 7) ? 16'hFFF0 : 16'(i + 1);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 1'b0);
    chk("reset_wren", bus.ram_wren, 1'b0);
    chk("reset_addr", bus.ram_addr, 16'h0);
    chk("reset_wdata", bus.ram_wdata, 16'h0);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_last", bus.out_last, 1'b0);
    chk("reset_out_id", bus.out_id, 16'h0);
    chk("reset_out_score", bus.out_score, 16'h0);
    chk("reset_parity", bus.out_parity, 1'b0);
    chk("reset_err", bus.err, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.cmd_ready, 1'b1);

    send_cmd(2'b10, 16'd5, 16'h0042, 1'b1, acc);
    chk("write_busy_n1", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk("write_ready_n2", bus.cmd_ready, 1'b1);
    wait_idle();

    send_cmd(2'b11, 16'd7, 16'h0020, 1'b1, acc);
    wait_idle();
    send_cmd(2'b11, 16'd3, 16'h0010, 1'b1, acc);
    wait_idle();
    send_cmd(2'b10, 16'd0, 16'hFFFF, 1'b1, acc);
    send_cmd(2'b11, 16'd0, 16'h0001, 1'b1, acc);
    wait_idle();

    send_cmd(2'b10, 16'd8, 16'h1111, 1'b1, acc);
    send_cmd(2'b10, 16'd300, 16'h2222, 1'b1, acc);
    send_cmd(2'b11, 16'd8, 16'h3333, 1'b1, acc);
    send_cmd(2'b10, 16'd7, 16'hBEEF, 1'b1, acc);
    wait_idle();

    send_cmd(2'b00, 16'd2, 16'h5555, 1'b1, acc);
    chk("nop_ready", bus.cmd_ready, 1'b1);
    wait_idle();

    send_cmd(2'b01, 16'd0, 16'h0, 1'b1, acc);
    wait_idle();
    chk("parity_after_dump", bus.out_parity, par_exp);

    stall_mode = 1'b1;
    stall_cnt  = 0;
    n_stalled  = 0;
    send_cmd(2'b01, 16'd0, 16'h0, 1'b1, acc);
    send_cmd(2'b10, 16'd0, 16'h1234, 1'b1, acc);
    wait_idle();
    chk("stall_cycles", n_stalled, 5);
    stall_mode = 1'b0;

    send_cmd(2'b01, 16'd0, 16'h0, 1'b1, acc);
    wait_idle();

    abort_mode = 1'b1;
    send_cmd(2'b01, 16'd0, 16'h0, 1'b1, acc);
    begin
      int i;
      i = 0;
      while (!(bus.out_valid && bus.out_id == 16'd1) && i < 200) begin
        @(negedge clk);
        i++;
      end
      if (i >= 200) chk("abort_beat_timeout", i, 0);
    end
    do_reset(2);
    abort_mode = 1'b0;
    repeat (20) @(negedge clk);

    send_cmd(2'b11, 16'd6, 16'h0100, 1'b0, acc);
    do_reset(2);
    repeat (10) @(negedge clk);

    send_cmd(2'b01, 16'd0, 16'h0, 1'b1, acc);
    wait_idle();
    chk("leftover", wr_q.size() + beat_q.size() + err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
